// File: rtl/flash_arb_pkg.sv
// Shared types and helpers for the two-port SPI flash arbiter.
`timescale 1ns/1ps
package flash_arb_pkg;

  // Arbiter sequencing: accept in IDLE, wait on flash in FETCH, pulse ready in RESPOND.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_t;

  // Index of a requester port (0 = instruction fetch, 1 = data/load).
  typedef logic port_idx_t;

  // Default flash byte-address width forwarded downstream.
  localparam int ADDR_BITS_DEFAULT = 24;

  // Decoded view of one requester's bus signals.
  typedef struct packed {
    logic pending;
    logic is_write;
  } req_decode_t;

  // A request is pending when selected and either reading or writing.
  // Read takes precedence when read and a write mask are both present.
  function automatic req_decode_t decode_req(input logic       sel,
                                             input logic       read,
                                             input logic [3:0] mask);
    req_decode_t d;
    d.pending  = sel && (read || (mask != 4'b0000));
    d.is_write = sel && !read && (mask != 4'b0000);
    return d;
  endfunction

endpackage

// File: rtl/flash_rr_arb.sv
// Two-way round-robin grant. When both ports request, the port that was
// not granted last wins; a single requester always wins. The last-grant
// register only moves when the owner accepts the grant (advance high).
`timescale 1ns/1ps
module flash_rr_arb
  import flash_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output port_idx_t  grant
);

  port_idx_t last_grant;

  // Pick the winner from the current requests and the last grant.
  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

  // Remember who won; reset value 1 lets port 0 win the first contest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (advance && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one SPI flash controller between an instruction-fetch port (0)
// and a data port (1), with a single-word read buffer in front of flash.
//
// Bus handshake (both upstream ports and the downstream side): the master
// holds sel plus read/mask stable until the slave's ready pulses for exactly
// one cycle; a new request may be presented in the cycle after that pulse.
// Downstream data is valid only in the flash_ready_in cycle.
`timescale 1ns/1ps
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int BUFFER_EN = 1,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] p0_address_in,
  input  logic        p0_sel_in,
  input  logic        p0_read_in,
  input  logic [3:0]  p0_write_mask_in,
  input  logic [31:0] p0_write_value_in,
  output logic [31:0] p0_read_value_out,
  output logic        p0_ready_out,

  input  logic [31:0] p1_address_in,
  input  logic        p1_sel_in,
  input  logic        p1_read_in,
  input  logic [3:0]  p1_write_mask_in,
  input  logic [31:0] p1_write_value_in,
  output logic [31:0] p1_read_value_out,
  output logic        p1_ready_out,

  output logic [31:0] flash_address_out,
  output logic        flash_sel_out,
  output logic        flash_read_out,
  output logic [3:0]  flash_write_mask_out,
  output logic [31:0] flash_write_value_out,
  input  logic [31:0] flash_read_value_in,
  input  logic        flash_ready_in
);

  localparam int WORD_BITS = ADDR_BITS - 2;

  arb_state_t           state;
  port_idx_t            grant_q;
  logic [WORD_BITS-1:0] word_q;
  logic [31:0]          resp_data;
  logic                 p0_ready_q;
  logic                 p1_ready_q;

  logic                 buf_valid;
  logic [WORD_BITS-1:0] buf_tag;
  logic [31:0]          buf_data;

  req_decode_t          p0_dec;
  req_decode_t          p1_dec;
  req_decode_t          sel_dec;
  logic [31:0]          sel_addr;
  logic [WORD_BITS-1:0] word_in;
  logic                 buf_hit;
  logic                 grant_valid;
  port_idx_t            grant;

  // Write data, byte-offset bits and address bits above the flash window
  // carry no meaning for a read-only flash.
  logic unused_inputs;
  assign unused_inputs = ^{p0_write_value_in, p1_write_value_in,
                           p0_address_in[31:ADDR_BITS], p0_address_in[1:0],
                           p1_address_in[31:ADDR_BITS], p1_address_in[1:0]};

  assign p0_dec = decode_req(p0_sel_in, p0_read_in, p0_write_mask_in);
  assign p1_dec = decode_req(p1_sel_in, p1_read_in, p1_write_mask_in);

  flash_rr_arb u_rr_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({p1_dec.pending, p0_dec.pending}),
    .advance     (state == ST_IDLE),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Steer the winning port's request and look it up in the read buffer.
  always_comb begin
    sel_addr = grant ? p1_address_in : p0_address_in;
    sel_dec  = grant ? p1_dec : p0_dec;
    word_in  = sel_addr[ADDR_BITS-1:2];
    buf_hit  = (BUFFER_EN != 0) && buf_valid && (buf_tag == word_in);
  end

  // Main sequencer: accept a request, optionally fetch from flash, then
  // pulse ready to the granted port for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_q    <= 1'b0;
      word_q     <= '0;
      resp_data  <= '0;
      p0_ready_q <= 1'b0;
      p1_ready_q <= 1'b0;
      buf_valid  <= 1'b0;
      buf_tag    <= '0;
      buf_data   <= '0;
    end else begin
      p0_ready_q <= 1'b0;
      p1_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            grant_q <= grant;
            word_q  <= word_in;
            if (sel_dec.is_write) begin
              // Flash is read-only: writes complete immediately with zero data.
              resp_data  <= '0;
              p0_ready_q <= (grant == 1'b0);
              p1_ready_q <= (grant == 1'b1);
              state      <= ST_RESPOND;
            end else if (buf_hit) begin
              resp_data  <= buf_data;
              p0_ready_q <= (grant == 1'b0);
              p1_ready_q <= (grant == 1'b1);
              state      <= ST_RESPOND;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          // No timeout: the flash controller always finishes its transaction.
          if (flash_ready_in) begin
            resp_data  <= flash_read_value_in;
            buf_data   <= flash_read_value_in;
            buf_tag    <= word_q;
            buf_valid  <= (BUFFER_EN != 0);
            p0_ready_q <= (grant_q == 1'b0);
            p1_ready_q <= (grant_q == 1'b1);
            state      <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          // Select is low here, so the controller cannot restart on a stale request.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Downstream master signals follow the FETCH state directly.
  always_comb begin
    flash_sel_out         = (state == ST_FETCH);
    flash_read_out        = (state == ST_FETCH);
    flash_address_out     = {{(32 - ADDR_BITS){1'b0}}, word_q, 2'b00};
    flash_write_mask_out  = 4'b0000;
    flash_write_value_out = 32'h0;
  end

  // Upstream responses: data only while ready, and only to a still-selected port.
  always_comb begin
    p0_ready_out      = p0_ready_q;
    p1_ready_out      = p1_ready_q;
    p0_read_value_out = (p0_ready_q && p0_sel_in) ? resp_data : 32'h0;
    p1_read_value_out = (p1_ready_q && p1_sel_in) ? resp_data : 32'h0;
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: directed scenarios plus concurrent random traffic
// on both ports, a downstream flash model, and a scoreboard monitor.
`timescale 1ns/1ps
module tb_flash_arbiter;

  localparam int BUFFER_EN = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic [31:0] p0_address_in = '0, p1_address_in = '0;
  logic        p0_sel_in = 1'b0, p1_sel_in = 1'b0;
  logic        p0_read_in = 1'b0, p1_read_in = 1'b0;
  logic [3:0]  p0_write_mask_in = '0, p1_write_mask_in = '0;
  logic [31:0] p0_write_value_in = '0, p1_write_value_in = '0;
  logic [31:0] p0_read_value_out, p1_read_value_out;
  logic        p0_ready_out, p1_ready_out;
  logic [31:0] flash_address_out;
  logic        flash_sel_out, flash_read_out;
  logic [3:0]  flash_write_mask_out;
  logic [31:0] flash_write_value_out;
  logic [31:0] flash_read_value_in = '0;
  logic        flash_ready_in = 1'b0;

  flash_arbiter #(.BUFFER_EN(BUFFER_EN), .ADDR_BITS(24)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .p0_address_in         (p0_address_in),
    .p0_sel_in             (p0_sel_in),
    .p0_read_in            (p0_read_in),
    .p0_write_mask_in      (p0_write_mask_in),
    .p0_write_value_in     (p0_write_value_in),
    .p0_read_value_out     (p0_read_value_out),
    .p0_ready_out          (p0_ready_out),
    .p1_address_in         (p1_address_in),
    .p1_sel_in             (p1_sel_in),
    .p1_read_in            (p1_read_in),
    .p1_write_mask_in      (p1_write_mask_in),
    .p1_write_value_in     (p1_write_value_in),
    .p1_read_value_out     (p1_read_value_out),
    .p1_ready_out          (p1_ready_out),
    .flash_address_out     (flash_address_out),
    .flash_sel_out         (flash_sel_out),
    .flash_read_out        (flash_read_out),
    .flash_write_mask_out  (flash_write_mask_out),
    .flash_write_value_out (flash_write_value_out),
    .flash_read_value_in   (flash_read_value_in),
    .flash_ready_in        (flash_ready_in)
  );

  // ---------------- counters / check helper ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash contents: static, one fixed word holds 0xDEADBEEF.
  function automatic logic [31:0] fdata(input logic [21:0] w);
    if (w == 22'h040001) return 32'hDEADBEEF;
    return {10'h2A5, w} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] data;
    logic [21:0] word;
    bit          is_read;
    int          issue_cyc;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          grant_log[$];
  bit          done[2];
  bit          mb_valid = 1'b0;
  logic [21:0] mb_tag = '0;
  int          last_served = 1;
  bit          solo = 1'b1;

  // ---------------- downstream flash model ----------------
  int          flash_lat = 0;
  int          txn_count = 0;
  int          last_txn = 0;
  logic [31:0] flash_addr_seen = '0;
  int          flash_ready_cyc = 0;

  initial begin
    forever begin
      @(negedge clk); #1;
      if (!reset && flash_sel_out && flash_read_out) begin
        int  lat;
        bit  aborted;
        lat = (flash_lat == 0) ? int'($urandom_range(1, 6)) : flash_lat;
        txn_count++;
        flash_addr_seen = flash_address_out;
        aborted = 1'b0;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk); #1;
          if (reset) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          flash_read_value_in = fdata(flash_address_out[23:2]);
          flash_ready_in      = 1'b1;
          flash_ready_cyc     = cyc;
          @(negedge clk); #1;
          flash_ready_in      = 1'b0;
          flash_read_value_in = $urandom;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_port(input int p, input logic sel, input logic rd,
                            input logic [3:0] mask, input logic [31:0] addr);
    if (p == 0) begin
      p0_sel_in = sel; p0_read_in = rd; p0_write_mask_in = mask;
      p0_address_in = addr; p0_write_value_in = $urandom;
    end else begin
      p1_sel_in = sel; p1_read_in = rd; p1_write_mask_in = mask;
      p1_address_in = addr; p1_write_value_in = $urandom;
    end
  endtask

  // Issue one request on port p and hold it until its ready pulse.
  task automatic do_req(input int p, input logic [31:0] addr, input logic rd,
                        input logic [3:0] mask);
    exp_t e;
    bit   got;
    @(negedge clk); #1;
    e.word      = addr[23:2];
    e.is_read   = rd;
    e.data      = rd ? fdata(addr[23:2]) : 32'h0;
    e.issue_cyc = cyc;
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    done[p] = 1'b0;
    drive_port(p, 1'b1, rd, mask, addr);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (done[p]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_port%0d: got no ready expected ready within 2000 cycles", p);
    end
    drive_port(p, 1'b0, 1'b0, 4'b0000, $urandom);
  endtask

  task automatic rand_port(input int p, input int count);
    logic [31:0] a;
    int          t;
    logic        rd;
    logic [3:0]  m;
    for (int k = 0; k < count; k++) begin
      a = {8'($urandom), 24'h100000 + 24'($urandom_range(0, 5) * 4 + $urandom_range(0, 3))};
      t = $urandom_range(0, 9);
      if (t < 6) begin
        rd = 1'b1; m = 4'b0000;
      end else if (t < 8) begin
        rd = 1'b0; m = 4'($urandom_range(1, 15));
      end else begin
        rd = 1'b1; m = 4'($urandom_range(1, 15));
      end
      do_req(p, a, rd, m);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic arb_round(input logic [31:0] a0, input logic [31:0] a1);
    int exp_first;
    exp_first = (last_served == 0) ? 1 : 0;
    grant_log.delete();
    fork
      do_req(0, a0, 1'b1, 4'b0000);
      do_req(1, a1, 1'b1, 4'b0000);
    join
    check("arb_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("arb_first", grant_log[0], exp_first);
      check("arb_second", grant_log[1], 1 - exp_first);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic handle(input int p);
    exp_t        e;
    logic [31:0] act;
    bit          fetched;
    bit          exp_fetch;
    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_ready_p%0d: got ready expected none", p);
      done[p] = 1'b1;
      return;
    end
    if (p == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    act = (p == 0) ? p0_read_value_out : p1_read_value_out;
    check($sformatf("read_value_p%0d", p), act, e.data);
    exp_fetch = e.is_read && !((BUFFER_EN != 0) && mb_valid && (mb_tag == e.word));
    fetched   = (txn_count != last_txn);
    check($sformatf("flash_fetch_p%0d", p), {31'b0, fetched}, {31'b0, exp_fetch});
    if (fetched) begin
      check("flash_address", flash_addr_seen, {8'h00, e.word, 2'b00});
      check("ready_after_flash_done", cyc, flash_ready_cyc + 1);
    end else if (solo) begin
      check("short_latency", cyc - e.issue_cyc, 1);
    end
    check("flash_sel_low_in_respond", {31'b0, flash_sel_out}, 32'h0);
    check("flash_write_outputs_zero", flash_write_value_out | {28'b0, flash_write_mask_out}, 32'h0);
    last_txn = txn_count;
    if (e.is_read && BUFFER_EN != 0) begin
      mb_valid = 1'b1;
      mb_tag   = e.word;
    end
    last_served = p;
    grant_log.push_back(p);
    done[p] = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && (p0_ready_out || p1_ready_out)) begin
        check("one_ready_at_a_time", {31'b0, p0_ready_out & p1_ready_out}, 32'h0);
        if (p0_ready_out) handle(0);
        if (p1_ready_out) handle(1);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of test expected end before 3ms");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_flash_sel", {31'b0, flash_sel_out}, 32'h0);
    check("reset_flash_read", {31'b0, flash_read_out}, 32'h0);
    check("reset_ready", {30'b0, p1_ready_out, p0_ready_out}, 32'h0);
    check("reset_read_values", p0_read_value_out | p1_read_value_out, 32'h0);
    check("reset_flash_address", flash_address_out, 32'h0);
    reset = 1'b0;

    // Miss, then hit on a different byte of the same word.
    flash_lat = 66;
    do_req(0, 32'h0010_0004, 1'b1, 4'b0000);
    flash_lat = 3;
    do_req(0, 32'h0010_0006, 1'b1, 4'b0000);
    // Write from port 1 completes at once and leaves the buffer intact.
    do_req(1, 32'h0010_0004, 1'b0, 4'b1111);
    do_req(0, 32'h0010_0004, 1'b1, 4'b0000);

    // Reset in the middle of a long fetch.
    flash_lat = 66;
    @(negedge clk); #1;
    drive_port(0, 1'b1, 1'b1, 4'b0000, 32'h0020_0010);
    repeat (30) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midfetch_reset_flash_sel", {31'b0, flash_sel_out}, 32'h0);
    check("midfetch_reset_flash_read", {31'b0, flash_read_out}, 32'h0);
    check("midfetch_reset_ready", {30'b0, p1_ready_out, p0_ready_out}, 32'h0);
    check("midfetch_reset_read_value", p0_read_value_out, 32'h0);
    check("midfetch_reset_address", flash_address_out, 32'h0);
    mb_valid    = 1'b0;
    last_served = 1;
    drive_port(0, 1'b0, 1'b0, 4'b0000, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    last_txn = txn_count;
    reset    = 1'b0;

    // Previously buffered word must now come from flash again.
    flash_lat = 4;
    do_req(0, 32'h0010_0004, 1'b1, 4'b0000);

    // Contention: the port that was not served last wins.
    solo = 1'b0;
    arb_round(32'h0010_0010, 32'h0010_0020);
    do_req(1, 32'h0010_0030, 1'b1, 4'b0000);
    arb_round(32'h0010_0040, 32'h0010_0050);

    // Concurrent random traffic on both ports.
    flash_lat = 0;
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join

    repeat (10) @(negedge clk);
    check("pending_p0_responses", exp_q0.size(), 0);
    check("pending_p1_responses", exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
- Shares the single SPI flash controller between two memory-bus requesters: port 0 (instruction fetch) and port 1 (data/load).
- Round-robin arbitration and a single-entry read buffer, so a repeated fetch of the same word needs no new ~66-cycle SPI transaction.
- Sits between the CPU-side bus decode and the flash controller. Presents the standard memory-bus slave interface upstream and the same interface, as master, downstream.

Parameters:
- BUFFER_EN, 1, 1 = single-word read buffer enabled; 0 = every read goes to flash.
- ADDR_BITS, 24, flash byte-address width forwarded downstream; upper address bits are ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p0_address_in / p1_address_in  in  32  requester byte address
- p0_sel_in / p1_sel_in  in  1  requester selects flash
- p0_read_in / p1_read_in  in  1  read request
- p0_write_mask_in / p1_write_mask_in  in  4  byte write mask; writes have no effect on flash
- p0_write_value_in / p1_write_value_in  in  32  unused write data
- p0_read_value_out / p1_read_value_out  out  32  read data; forced to 0 when that port's sel_in is low
- p0_ready_out / p1_ready_out  out  1  one-cycle completion pulse
- flash_address_out  out  32  {8'b0, word address, 2'b00}
- flash_sel_out  out  1  downstream select
- flash_read_out  out  1  downstream read
- flash_write_mask_out  out  4  always 0
- flash_write_value_out  out  32  always 0
- flash_read_value_in  in  32  downstream data, valid with flash_ready_in
- flash_ready_in  in  1  downstream one-cycle done pulse

Behaviour:
- Requester protocol: hold sel (plus read or mask) stable until ready_out. ready_out is a single-cycle pulse. A new request may be presented the cycle after ready_out.
- States: IDLE, FETCH, RESPOND.
- Reset (asynchronous):
  - state = IDLE, buf_valid = 0, last_grant = 1 (port 0 wins first), both ready_out = 0.
  - flash_sel_out = 0, flash_read_out = 0. Response data register = 0.
- IDLE: a port is pending when sel_in is high and (read_in is high or write_mask_in is nonzero).
  - Both pending: grant the port != last_grant. Otherwise grant the single pending port.
  - Latch grant, word address address_in[ADDR_BITS-1:2], and request type. Update last_grant.
  - Write (mask != 0, read_in low): go to RESPOND, response data = 0, no flash access.
  - Read with BUFFER_EN, buf_valid set and tag == word address: hit. Go to RESPOND with buffer data; 1-cycle latency, ready on the second cycle.
  - Read otherwise: go to FETCH.
  - Read and write both asserted: treat as a read.
- FETCH:
  - flash_sel_out = 1 and flash_read_out = 1, driven combinationally from state. Address comes from the latched word address.
  - Wait for flash_ready_in. There is no timeout.
  - On flash_ready_in: capture flash_read_value_in into the response register and the buffer, set tag and buf_valid, go to RESPOND.
- RESPOND:
  - Granted port's ready_out = 1; its read_value_out = response register, gated by its sel_in. The other port's outputs are 0.
  - Next state is IDLE.
  - flash_sel_out is low in this cycle, so the downstream controller, which returns to idle after its done cycle, never sees a stale select and never starts a spurious transaction.
- No request is accepted in FETCH or RESPOND. A losing port waits in IDLE arbitration; round-robin bounds its wait to one transaction.
- A requester that drops sel mid-FETCH is a protocol violation. The transaction still completes, the buffer is updated, and the ready pulse is issued; read_value_out reads 0 because of the gating.
- Reset mid-FETCH: abort to IDLE and invalidate the buffer. The downstream controller is reset by the same signal.
- BUFFER_EN = 0: buf_valid is held at 0.

Decomposition:
- Package flash_arb_pkg:
  - state enum (IDLE/FETCH/RESPOND)
  - port-index typedef
  - ADDR_BITS default
  - request-decode helper (pending, is_write)
- Optional sub-module flash_rr_arb (2-way round-robin grant with last_grant register), reusable for other shared slaves. The rest stays in flash_arbiter.

Test Plan:
- Port 0 read 0x00100004 with a downstream model returning 0xDEADBEEF after 66 cycles -> flash_address_out = 0x00100004 during FETCH; p0_ready_out pulses the cycle after flash_ready_in; p0_read_value_out = 0xDEADBEEF; flash_sel_out low that cycle.
- Port 0 re-reads 0x00100006 -> buffer hit (same word), ready on cycle 2, no flash_sel_out, data 0xDEADBEEF. Repeat with BUFFER_EN = 0 -> full flash fetch.
- p0 and p1 both read different words from reset -> p0 served first, then p1. Both request again -> p1 then p0 (alternation). No cycle with both ready_out high.
- p1 write mask 4'b1111 to 0x00100004 -> ready on cycle 2, read_value 0, no flash access. A subsequent p0 read of the same word still hits with 0xDEADBEEF.
- Reset asserted mid-FETCH (cycle 30) -> immediate IDLE, all outputs 0. A re-read of a previously buffered word triggers a flash fetch (buffer invalidated).
